// File: rtl/frame_sequencer.sv
// Fixed-rate frame scheduler: per-frame button sampling, one step/commit handshake
// with the player datapath, and a terminal HALT on exit. Optional macro: SINGLE_STEP_EN.
module frame_sequencer #(
  parameter int TICK_DIV     = 833334,
  parameter int DIV_W        = 20,
  parameter int STEP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  btn,
  input  logic        step_done_i,
  input  logic        exit_i,
`ifdef SINGLE_STEP_EN
  input  logic        dbg_step_i,
`endif
  output logic        step_o,
  output logic        commit_o,
  output logic [5:0]  frame_btn_o,
  output logic [5:0]  frame_press_o,
  output logic [15:0] frame_cnt_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        timeout_o,
  output logic        exit_o
);

  localparam int TO_W = $clog2(STEP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_STEP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [5:0]        sync1_q, sync1_d;
  logic [5:0]        sync2_q, sync2_d;
  logic [5:0]        frame_btn_q, frame_btn_d;
  logic [5:0]        frame_press_q, frame_press_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              exit_q, exit_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              tick;
  logic              frame_start;
  logic              active;

  assign tick = (div_q == DIV_W'(TICK_DIV - 1));

`ifdef SINGLE_STEP_EN
  logic dbg_s_q, dbg_s_d;
  logic dbg_prev_q, dbg_prev_d;

  assign dbg_s_d     = dbg_step_i;
  assign dbg_prev_d  = dbg_s_q;
  assign frame_start = dbg_s_q & ~dbg_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_s_q    <= 1'b0;
      dbg_prev_q <= 1'b0;
    end else begin
      dbg_s_q    <= dbg_s_d;
      dbg_prev_q <= dbg_prev_d;
    end
  end
`else
  assign frame_start = tick;
`endif

  // A frame-start event is only lost when a frame is in flight; HALT swallows it silently.
  assign active = (state_q != ST_IDLE) && (state_q != ST_HALT);

  always_comb begin
    state_d       = state_q;
    div_d         = tick ? '0 : div_q + DIV_W'(1);
    sync1_d       = btn;
    sync2_d       = sync1_q;
    frame_btn_d   = frame_btn_q;
    frame_press_d = frame_press_q;
    frame_cnt_d   = frame_cnt_q;
    to_cnt_d      = to_cnt_q;
    exit_d        = exit_q;
    overrun_d     = overrun_q | (frame_start & active);
    timeout_d     = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        frame_btn_d   = sync2_q;
        frame_press_d = sync2_q & ~frame_btn_q;
        state_d       = ST_STEP;
      end
      ST_STEP: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion wins over a timeout that would expire in the same cycle.
        if (step_done_i) begin
          exit_d  = exit_i;
          state_d = ST_COMMIT;
        end else if (to_cnt_q == TO_W'(STEP_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_COMMIT: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = exit_q ? ST_HALT : ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      frame_btn_q   <= '0;
      frame_press_q <= '0;
      frame_cnt_q   <= '0;
      to_cnt_q      <= '0;
      exit_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      frame_btn_q   <= frame_btn_d;
      frame_press_q <= frame_press_d;
      frame_cnt_q   <= frame_cnt_d;
      to_cnt_q      <= to_cnt_d;
      exit_q        <= exit_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign step_o        = (state_q == ST_STEP);
  assign commit_o      = (state_q == ST_COMMIT);
  assign busy_o        = (state_q != ST_IDLE);
  assign exit_o        = (state_q == ST_HALT);
  assign frame_btn_o   = frame_btn_q;
  assign frame_press_o = frame_press_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign overrun_o     = overrun_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: table of per-frame vectors on one instance
// (TICK_DIV=16, STEP_TIMEOUT=8) plus a hand-written overrun sequence on a second (STEP_TIMEOUT=32).
module tb_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [5:0]  btn;
  logic        done_a, exit_a, done_b, exit_b;

  logic        a_step, a_commit, a_busy, a_overrun, a_timeout, a_exit;
  logic [5:0]  a_frame_btn, a_frame_press;
  logic [15:0] a_frame_cnt;
  logic        b_step, b_commit, b_busy, b_overrun, b_timeout, b_exit;
  logic [5:0]  b_frame_btn, b_frame_press;
  logic [15:0] b_frame_cnt;

  frame_sequencer #(.TICK_DIV(16), .DIV_W(4), .STEP_TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst_a), .btn(btn), .step_done_i(done_a), .exit_i(exit_a),
    .step_o(a_step), .commit_o(a_commit), .frame_btn_o(a_frame_btn),
    .frame_press_o(a_frame_press), .frame_cnt_o(a_frame_cnt), .busy_o(a_busy),
    .overrun_o(a_overrun), .timeout_o(a_timeout), .exit_o(a_exit)
  );

  frame_sequencer #(.TICK_DIV(16), .DIV_W(4), .STEP_TIMEOUT(32)) dut_b (
    .clk(clk), .rst(rst_b), .btn(btn), .step_done_i(done_b), .exit_i(exit_b),
    .step_o(b_step), .commit_o(b_commit), .frame_btn_o(b_frame_btn),
    .frame_press_o(b_frame_press), .frame_cnt_o(b_frame_cnt), .busy_o(b_busy),
    .overrun_o(b_overrun), .timeout_o(b_timeout), .exit_o(b_exit)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int base_a = 0;
  int base_b = 0;

  typedef struct {
    logic [5:0]  btn;
    int          delay;      // cycles from step_o to step_done_i; -1 never answers
    logic        exit_in;
    int          exp_step;   // step_o cycle relative to reset release
    logic [5:0]  exp_btn;
    logic [5:0]  exp_press;
    logic [15:0] exp_cnt;
    logic        exp_to;
    logic        exp_exit;
  } frame_vec_t;

  frame_vec_t vec [7];

  function automatic frame_vec_t mk(input logic [5:0] b, input int d, input logic ex, input int st,
                                    input logic [5:0] eb, input logic [5:0] ep, input logic [15:0] ec,
                                    input logic eto, input logic eex);
    frame_vec_t v;
    v.btn = b; v.delay = d; v.exit_in = ex; v.exp_step = st; v.exp_btn = eb;
    v.exp_press = ep; v.exp_cnt = ec; v.exp_to = eto; v.exp_exit = eex;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_step_a(output int rel, output bit ok);
    ok  = 1'b0;
    rel = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (a_step === 1'b1) begin
        ok  = 1'b1;
        rel = cyc - base_a;
        break;
      end
    end
  endtask

  task automatic run_frame(input int i);
    int s;
    bit ok;
    int commits;
    btn = vec[i].btn;
    wait_step_a(s, ok);
    check("step_seen", 32'(ok), 32'd1);
    if (!ok) return;
    check("step_cycle", s, vec[i].exp_step);
    check("frame_btn", 32'(a_frame_btn), 32'(vec[i].exp_btn));
    check("frame_press", 32'(a_frame_press), 32'(vec[i].exp_press));
    if (vec[i].delay < 0) begin
      commits = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        commits += int'(a_commit);
      end
      check("busy_last_wait", 32'(a_busy), 32'd1);
      @(negedge clk);
      commits += int'(a_commit);
      check("timeout_commits", commits, 0);
      check("timeout_flag", 32'(a_timeout), 32'(vec[i].exp_to));
      check("timeout_idle", 32'(a_busy), 32'd0);
      check("timeout_cnt", 32'(a_frame_cnt), 32'(vec[i].exp_cnt));
    end else begin
      repeat (vec[i].delay) @(negedge clk);
      done_a = 1'b1;
      exit_a = vec[i].exit_in;
      @(negedge clk);
      done_a = 1'b0;
      exit_a = 1'b0;
      check("commit_pulse", 32'(a_commit), 32'd1);
      @(negedge clk);
      check("commit_end", 32'(a_commit), 32'd0);
      check("frame_cnt", 32'(a_frame_cnt), 32'(vec[i].exp_cnt));
      check("exit_flag", 32'(a_exit), 32'(vec[i].exp_exit));
      check("timeout_flag", 32'(a_timeout), 32'(vec[i].exp_to));
    end
    $display("frame %0d step@%0d btn=%b press=%b cnt=%0d to=%b exit=%b",
             i, s, a_frame_btn, a_frame_press, a_frame_cnt, a_timeout, a_exit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bit ok;
    int steps, commits, not_exit, s_b, k;

    // Phase 1: free run, button edges, timeout. Phase 2 (after reset): exit on frame 3.
    vec[0] = mk(6'b000001,  2, 1'b0, 17, 6'b000001, 6'b000001, 16'd1, 1'b0, 1'b0);
    vec[1] = mk(6'b000001,  2, 1'b0, 33, 6'b000001, 6'b000000, 16'd2, 1'b0, 1'b0);
    vec[2] = mk(6'b000011,  2, 1'b0, 49, 6'b000011, 6'b000010, 16'd3, 1'b0, 1'b0);
    vec[3] = mk(6'b000011, -1, 1'b0, 65, 6'b000011, 6'b000000, 16'd3, 1'b1, 1'b0);
    vec[4] = mk(6'b100000,  2, 1'b0, 17, 6'b100000, 6'b100000, 16'd1, 1'b0, 1'b0);
    vec[5] = mk(6'b110000,  2, 1'b0, 33, 6'b110000, 6'b010000, 16'd2, 1'b0, 1'b0);
    vec[6] = mk(6'b010000,  2, 1'b1, 49, 6'b010000, 6'b000000, 16'd3, 1'b0, 1'b1);

    rst_a = 1'b0; rst_b = 1'b0;
    btn = vec[0].btn;
    done_a = 1'b0; exit_a = 1'b0; done_b = 1'b0; exit_b = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_a_flags", 32'({a_step, a_commit, a_busy, a_overrun, a_timeout, a_exit}), 32'd0);
    check("reset_a_btns", 32'({a_frame_btn, a_frame_press}), 32'd0);
    check("reset_a_cnt", 32'(a_frame_cnt), 32'd0);
    check("reset_b_flags", 32'({b_step, b_commit, b_busy, b_overrun, b_timeout, b_exit}), 32'd0);

    rst_a = 1'b1;
    base_a = cyc;
    for (int i = 0; i < 4; i++) run_frame(i);

    // Asynchronous reset in the middle of WAIT.
    wait_step_a(s, ok);
    check("pre_reset_step", s, 81);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(a_busy), 32'd1);
    check("pre_reset_cnt", 32'(a_frame_cnt), 32'd3);
    #2 rst_a = 1'b0;
    #1;
    check("async_reset_flags", 32'({a_step, a_commit, a_busy, a_overrun, a_timeout, a_exit}), 32'd0);
    check("async_reset_btns", 32'({a_frame_btn, a_frame_press}), 32'd0);
    check("async_reset_cnt", 32'(a_frame_cnt), 32'd0);
    $display("async reset applied mid-WAIT at cycle %0d", cyc);
    btn = vec[4].btn;
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    base_a = cyc;
    for (int i = 4; i < 7; i++) run_frame(i);

    // HALT must hold with no further step/commit, ignoring ticks.
    steps = 0; commits = 0; not_exit = 0;
    repeat (70) begin
      @(negedge clk);
      steps    += int'(a_step);
      commits  += int'(a_commit);
      not_exit += int'(!a_exit);
    end
    check("halt_no_step", steps, 0);
    check("halt_no_commit", commits, 0);
    check("halt_exit_low_cycles", not_exit, 0);
    check("halt_busy", 32'(a_busy), 32'd1);
    check("halt_cnt", 32'(a_frame_cnt), 32'd3);
    check("a_no_overrun", 32'(a_overrun), 32'd0);
    $display("halt window: steps=%0d commits=%0d exit=%b", steps, commits, a_exit);

    // Overrun on instance B: step_done_i 20 cycles after step_o.
    rst_b = 1'b1;
    base_b = cyc;
    s_b = -1;
    for (k = 0; k < 64; k++) begin
      @(negedge clk);
      if (b_step === 1'b1) begin
        s_b = cyc;
        break;
      end
    end
    check("b_step_seen", 32'(s_b >= 0), 32'd1);
    if (s_b >= 0) begin
      check("b_step_cycle", s_b - base_b, 17);
      repeat (14) @(negedge clk);
      check("b_overrun_before_tick", 32'(b_overrun), 32'd0);
      @(negedge clk);
      check("b_overrun_after_tick", 32'(b_overrun), 32'd1);
      repeat (5) @(negedge clk);
      done_b = 1'b1;
      @(negedge clk);
      done_b = 1'b0;
      check("b_commit_pulse", 32'(b_commit), 32'd1);
      @(negedge clk);
      check("b_cnt_1", 32'(b_frame_cnt), 32'd1);
      check("b_idle", 32'(b_busy), 32'd0);
      $display("B frame 1 step@%0d committed cnt=%0d overrun=%b", s_b - base_b, b_frame_cnt, b_overrun);
      k = 0;
      while (k < 64 && b_step !== 1'b1) begin
        @(negedge clk);
        k++;
      end
      check("b_next_step_gap", cyc - s_b, 32);
      repeat (2) @(negedge clk);
      done_b = 1'b1;
      @(negedge clk);
      done_b = 1'b0;
      check("b_commit2_pulse", 32'(b_commit), 32'd1);
      @(negedge clk);
      check("b_cnt_2", 32'(b_frame_cnt), 32'd2);
      check("b_overrun_sticky", 32'(b_overrun), 32'd1);
      check("b_no_timeout", 32'(b_timeout), 32'd0);
      $display("B frame 2 committed cnt=%0d overrun=%b", b_frame_cnt, b_overrun);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
